// File: rtl/fv_bank_cntl.sv
// Feature-vector bank controller: fetches WORDS consecutive SRAM words for one
// latched request and streams them to the requesting PE through a 2-entry FIFO.
module fv_bank_cntl #(
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 2,
    parameter int ENTRY_W = 4,
    parameter int WORDS   = 4,
    localparam int WL     = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [TAG_W-1:0]      req_pe_tag,
    input  logic [ENTRY_W-1:0]    req_entry,
    output logic                  bank_busy,
    output logic                  sram_cen,
    output logic [ENTRY_W+WL-1:0] sram_addr,
    input  logic [DATA_W-1:0]     sram_q,
    output logic                  pe_valid,
    input  logic                  pe_ready,
    output logic [DATA_W-1:0]     pe_data,
    output logic [TAG_W-1:0]      pe_tag,
    output logic                  pe_last,
    output logic                  drop_err,
    output logic [1:0]            dbg_state
);

    localparam int CNT_W = WL + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [ENTRY_W-1:0]   entry_q, entry_d;
    logic [CNT_W-1:0]     issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]     out_cnt_q, out_cnt_d;
    logic                 inflight_q;
    logic [DATA_W-1:0]    fifo_q [2];
    logic                 wr_ptr_q, rd_ptr_q;
    logic [1:0]           count_q, count_d;
    logic                 drop_q;

    logic                 push, pop, issue;
    logic [2:0]           occ;

    // Handshake: a word transfers in any cycle with pe_valid=1 and pe_ready=1;
    // once pe_valid rises, data/tag/last hold until that transfer happens.
    assign pe_valid = (count_q != 2'd0);
    assign pop      = pe_valid & pe_ready;
    assign push     = inflight_q;

    // Issue only if the FIFO is guaranteed a free slot when the data returns.
    assign occ   = {1'b0, count_q} + {2'b0, inflight_q};
    assign issue = (state_q == READ) && (occ < (3'd2 + {2'b0, pop}));

    assign count_d = count_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        entry_d     = entry_q;
        issue_cnt_d = issue_cnt_q;
        out_cnt_d   = out_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tag_d       = req_pe_tag;
                    entry_d     = req_entry;
                    issue_cnt_d = '0;
                    out_cnt_d   = '0;
                    state_d     = READ;
                end
            end
            READ: begin
                if (issue) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    if (issue_cnt_q == LAST) state_d = DRAIN;
                end
            end
            DRAIN: ;
            default: state_d = IDLE;
        endcase
        if (pop && (state_q != IDLE)) begin
            out_cnt_d = out_cnt_q + 1'b1;
            if (out_cnt_q == LAST) state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tag_q       <= '0;
            entry_q     <= '0;
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            entry_q     <= entry_d;
            issue_cnt_q <= issue_cnt_d;
            out_cnt_q   <= out_cnt_d;
            inflight_q  <= issue;
            if (push) begin
                fifo_q[wr_ptr_q] <= sram_q;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q     <= count_d;
            if (req_valid && (state_q != IDLE)) drop_q <= 1'b1;
        end
    end

    assign sram_cen  = ~issue;
    assign sram_addr = issue ? {entry_q, issue_cnt_q[WL-1:0]} : '0;
    assign pe_data   = pe_valid ? fifo_q[rd_ptr_q] : '0;
    assign pe_tag    = tag_q;
    assign pe_last   = pe_valid && (out_cnt_q == LAST);
    assign bank_busy = (state_q != IDLE);
    assign drop_err  = drop_q;
    assign dbg_state = state_q;

endmodule

// File: doc/fv_bank_cntl.md
FV_BANK_CNTL -- requirements
Module: fv_bank_cntl

Interface
REQ-001 Parameter: DATA_W, default 16, feature-vector word width in bits.
REQ-002 Parameter: TAG_W, default 2, PE tag width in bits.
REQ-003 Parameter: ENTRY_W, default 4, width of the feature-vector entry index within one bank.
REQ-004 Parameter: WORDS, default 4, power of two ≥2, words per feature vector; WL = log2(WORDS).
REQ-005 The block SHALL use one clock, clk; reset is asynchronous and active-low, named reset.
REQ-006 Port: clk  in  1  clock.
REQ-007 Port: reset  in  1  asynchronous active-low reset.
REQ-008 Port: req_valid  in  1  routed request from the FV memory controller for this bank.
REQ-009 Port: req_pe_tag  in  TAG_W  requesting PE.
REQ-010 Port: req_entry  in  ENTRY_W  entry index (FV_Bank_addr).
REQ-011 Port: bank_busy  out  1  bank occupied; feeds that controller's Bank_busy bit.
REQ-012 Port: sram_cen  out  1  active-low SRAM read enable.
REQ-013 Port: sram_addr  out  ENTRY_W+WL  SRAM word address.
REQ-014 Port: sram_q  in  DATA_W  SRAM read data, valid the cycle after sram_cen=0.
REQ-015 Port: pe_valid  out  1  output word valid.
REQ-016 Port: pe_ready  in  1  PE accepts word.
REQ-017 Port: pe_data / pe_tag / pe_last  out  DATA_W / TAG_W / 1  word, tag, final-word flag.
REQ-018 Port: drop_err  out  1  sticky flag: request arrived while busy.

Function
REQ-019 States SHALL be IDLE, READ (issuing reads), DRAIN (all reads issued, buffer emptying).
REQ-020 In IDLE, req_valid=1 SHALL latch tag and entry, clear word counters, and move to READ; bank_busy (registered, = state≠IDLE) is 1 from the next cycle.
REQ-021 req_valid=1 while state≠IDLE SHALL be ignored and SHALL set drop_err until reset.
REQ-022 Word k (0..WORDS-1) SHALL be read from sram_addr = {entry, k[WL-1:0]}, in ascending order, each exactly once.
REQ-023 A 2-entry output FIFO SHALL hold returned words; one read is in flight at most; read issues (sram_cen=0) in READ only when occupancy + in_flight − (pe_valid&pe_ready) < 2.
REQ-024 sram_cen SHALL be 1 in every cycle without an issue; sram_addr is don't-care then.
REQ-025 sram_q SHALL be written into the FIFO at the end of the cycle after issue; FIFO head drives pe_data; pe_valid = FIFO non-empty.
REQ-026 pe_data/pe_tag/pe_last SHALL hold stable while pe_valid=1 and pe_ready=0.
REQ-027 pe_tag SHALL equal the latched tag for all words; pe_last=1 only on word WORDS-1.
REQ-028 After the issue of word WORDS-1, READ SHALL move to DRAIN; the handshake of the pe_last word SHALL move to IDLE.
REQ-029 Simultaneous FIFO push and pop SHALL leave occupancy unchanged; with pe_ready held 1, throughput SHALL be one word per cycle.
REQ-030 Latency: req_valid in cycle 0 -> first issue cycle 1 -> first pe_valid cycle 3; with pe_ready=1, last word cycle 2+WORDS, bank_busy=0 from cycle 3+WORDS, new request accepted that cycle.
REQ-031 Word counters SHALL be WL+1 bits; no wrap beyond WORDS.

Reset
REQ-032 reset=0 SHALL asynchronously force IDLE, empty FIFO, in_flight=0, counters 0, bank_busy=0, sram_cen=1, sram_addr=0, pe_valid=0, pe_data=0, pe_tag=0, pe_last=0, drop_err=0.
REQ-033 Reset mid-transfer SHALL abort it; no remaining words are output after release; outstanding SRAM data is discarded.

Verification
REQ-034 WORDS=4, req entry=5 tag=2, pe_ready=1 -> addrs 20,21,22,23 cycles 1-4; pe_valid cycles 3-6, tag 2, pe_last cycle 6; bank_busy cycles 1-6.
REQ-035 pe_ready=0 cycles 3-8 -> exactly 2 reads issued before stall, pe_data holds word0, no words lost or duplicated after release.
REQ-036 Second req_valid in cycle 2 -> ignored, drop_err=1 from cycle 3 until reset, first transfer unaffected.
REQ-037 reset=0 asserted in cycle 4 of a transfer -> all outputs at reset values immediately; after release no pe_valid until a new request.
REQ-038 Back-to-back: new req_valid in first cycle with bank_busy=0 -> accepted, addresses of new entry, pe_tag updated.
REQ-039 Random pe_ready toggling, 200 requests -> scoreboard: per request, WORDS words in order, matching SRAM model, correct tag, single pe_last.
